// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: register enables and bubbles,
// ID-stage forwarding selects, data-memory wait sequencing with timeout, stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset_0,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic [4:0]       rw_ex,
  input  logic             wreg_ex,
  input  logic             m2reg_ex,
  input  logic [4:0]       rw_me,
  input  logic             wreg_me,
  input  logic             m2reg_me,
  input  logic             mem_req_me,
  input  logic             mem_ack,
  input  logic [4:0]       rw_wb,
  input  logic             wreg_wb,
  input  logic             redirect_ex,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exme,
  output logic             en_mewb,
  output logic             bubble_ifid,
  output logic             bubble_idex,
  output logic             bubble_mewb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {RUN = 1'b0, MWAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t           state_r, state_nxt_s;
  logic [7:0]       wait_cnt_r, wait_cnt_nxt_s;
  logic             mem_err_r, err_set_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             timeout_s, mstall_s, luse_s;

  // ME has priority over WB; register 0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel_f(
    input logic [4:0] r, input logic wme, input logic [4:0] rme, input logic lme,
    input logic wwb, input logic [4:0] rwb
  );
    logic [1:0] sel;
    if (r == 5'd0) begin
      sel = 2'b00;
    end else if (wme && (rme == r)) begin
      sel = lme ? 2'b10 : 2'b01;
    end else if (wwb && (rwb == r)) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign timeout_s = (state_r == MWAIT) && (wait_cnt_r == TIMEOUT_C);
  assign mstall_s  = mem_req_me && !mem_ack && !timeout_s;
  assign luse_s    = wreg_ex && m2reg_ex && (rw_ex != 5'd0) &&
                     ((use_rs_id && (rs_id == rw_ex)) || (use_rt_id && (rt_id == rw_ex)));

  // State, wait counter, sticky error flag and saturating stall counter.
  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      state_r     <= RUN;
      wait_cnt_r  <= 8'd0;
      mem_err_r   <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      if (err_set_s) begin
        mem_err_r <= 1'b1;
      end
      if (!en_pc && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state logic for the memory wait sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    err_set_s      = 1'b0;
    case (state_r)
      RUN: begin
        if (mem_req_me && !mem_ack) begin
          state_nxt_s    = MWAIT;
          wait_cnt_nxt_s = 8'd1;
        end else begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = 8'd0;
        end
      end
      MWAIT: begin
        if (!mem_req_me || mem_ack) begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = 8'd0;
        end else if (timeout_s) begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = 8'd0;
          err_set_s      = 1'b1;
        end else begin
          state_nxt_s    = MWAIT;
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s    = RUN;
        wait_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Pipeline controls: mstall > redirect > load-use > normal; all quiet in reset.
  always_comb begin
    en_pc       = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exme     = 1'b0;
    en_mewb     = 1'b0;
    bubble_ifid = 1'b0;
    bubble_idex = 1'b0;
    bubble_mewb = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (!reset_0) begin
      en_pc = 1'b0;
    end else begin
      fwd_a = fwd_sel_f(rs_id, wreg_me, rw_me, m2reg_me, wreg_wb, rw_wb);
      fwd_b = fwd_sel_f(rt_id, wreg_me, rw_me, m2reg_me, wreg_wb, rw_wb);
      if (mstall_s) begin
        en_mewb     = 1'b1;
        bubble_mewb = 1'b1;
      end else if (redirect_ex) begin
        {en_pc, en_ifid, en_idex, en_exme, en_mewb} = 5'b11111;
        bubble_ifid = 1'b1;
        bubble_idex = 1'b1;
      end else if (luse_s) begin
        {en_idex, en_exme, en_mewb} = 3'b111;
        bubble_idex = 1'b1;
      end else begin
        {en_pc, en_ifid, en_idex, en_exme, en_mewb} = 5'b11111;
      end
    end
  end

  assign mem_err   = mem_err_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl with a queue-based scoreboard.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_0;
  logic [4:0]    rs_id, rt_id, rw_ex, rw_me, rw_wb;
  logic          use_rs_id, use_rt_id, wreg_ex, m2reg_ex, wreg_me, m2reg_me;
  logic          mem_req_me, mem_ack, wreg_wb, redirect_ex;
  logic          en_pc, en_ifid, en_idex, en_exme, en_mewb;
  logic          bubble_ifid, bubble_idex, bubble_mewb, mem_err;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset_0(reset_0), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .rw_ex(rw_ex), .wreg_ex(wreg_ex),
    .m2reg_ex(m2reg_ex), .rw_me(rw_me), .wreg_me(wreg_me), .m2reg_me(m2reg_me),
    .mem_req_me(mem_req_me), .mem_ack(mem_ack), .rw_wb(rw_wb), .wreg_wb(wreg_wb),
    .redirect_ex(redirect_ex), .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exme(en_exme), .en_mewb(en_mewb), .bubble_ifid(bubble_ifid),
    .bubble_idex(bubble_idex), .bubble_mewb(bubble_mewb), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  // ctrl = {en_pc, en_ifid, en_idex, en_exme, en_mewb, bubble_ifid, bubble_idex, bubble_mewb}
  typedef struct {
    logic [7:0] ctrl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
    int         cnt;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_n  = 0;

  // Reference state: stall cycles already spent on the current request, error, count.
  int   m_spent = 0;
  logic m_err   = 1'b0;
  int   m_cnt   = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (wreg_me && rw_me == r) return m2reg_me ? 2'b10 : 2'b01;
    if (wreg_wb && rw_wb == r) return 2'b11;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input int act, input int exp, input int tag);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", name, tag, act, exp);
    end
  endtask

  task automatic idle();
    {rs_id, rt_id, rw_ex, rw_me, rw_wb} = 25'd0;
    {use_rs_id, use_rt_id, wreg_ex, m2reg_ex, wreg_me, m2reg_me} = 6'd0;
    {mem_req_me, mem_ack, wreg_wb, redirect_ex} = 4'd0;
  endtask

  // Inputs are already set; predict this cycle's outputs, push, then advance one clock.
  task automatic step();
    exp_t e;
    logic mst, lu;
    e.tag = tag_n++;
    if (!reset_0) begin
      m_spent = 0; m_err = 1'b0; m_cnt = 0;
      e.ctrl = 8'd0; e.fa = 2'b00; e.fb = 2'b00; e.err = 1'b0; e.cnt = 0;
    end else begin
      mst = mem_req_me && !mem_ack && (m_spent < TO);
      lu  = wreg_ex && m2reg_ex && rw_ex != 5'd0 &&
            ((use_rs_id && rs_id == rw_ex) || (use_rt_id && rt_id == rw_ex));
      if (mst)              e.ctrl = 8'b00001_001;
      else if (redirect_ex) e.ctrl = 8'b11111_110;
      else if (lu)          e.ctrl = 8'b00111_010;
      else                  e.ctrl = 8'b11111_000;
      e.fa  = ref_fwd(rs_id);
      e.fb  = ref_fwd(rt_id);
      e.err = m_err;
      e.cnt = m_cnt;
      if (!e.ctrl[7] && m_cnt < (1 << CW) - 1) m_cnt++;
      if (mem_req_me && !mem_ack) begin
        if (m_spent < TO) m_spent++;
        else begin m_spent = 0; m_err = 1'b1; end
      end else begin
        m_spent = 0;
      end
    end
    sb.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    idle(); reset_0 = 1'b0; step(); reset_0 = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents a full set of outputs, compared mid-cycle.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ctrl", int'({en_pc, en_ifid, en_idex, en_exme, en_mewb,
                        bubble_ifid, bubble_idex, bubble_mewb}), int'(e.ctrl), e.tag);
      chk("fwd_a", int'(fwd_a), int'(e.fa), e.tag);
      chk("fwd_b", int'(fwd_b), int'(e.fb), e.tag);
      chk("mem_err", int'(mem_err), int'(e.err), e.tag);
      chk("stall_cnt", int'(stall_cnt), e.cnt, e.tag);
    end
  end

  initial begin
    idle();
    reset_0 = 1'b0;
    @(posedge clock); #1;
    // Reset with a pending stall, redirect active, then release into mstall.
    mem_req_me = 1'b1; redirect_ex = 1'b1;
    step(); step();
    reset_0 = 1'b1;
    step(); step();
    // Load-use: one bubble, then the load sits in ME and forwards as load data.
    do_reset();
    rw_ex = 5'd5; wreg_ex = 1'b1; m2reg_ex = 1'b1; rs_id = 5'd5; use_rs_id = 1'b1;
    step();
    idle(); rw_me = 5'd5; wreg_me = 1'b1; m2reg_me = 1'b1; rs_id = 5'd5; use_rs_id = 1'b1;
    step();
    idle(); step();
    // Forward priority ME ALU over WB, and register 0.
    rw_me = 5'd7; wreg_me = 1'b1; rw_wb = 5'd7; wreg_wb = 1'b1; rs_id = 5'd7; rt_id = 5'd7;
    step();
    idle(); rw_me = 5'd0; wreg_me = 1'b1; rs_id = 5'd0; rt_id = 5'd3; rw_wb = 5'd3; wreg_wb = 1'b1;
    step();
    // Memory wait of three cycles, then ack; same-cycle ack gives no stall.
    do_reset();
    mem_req_me = 1'b1;
    repeat (3) step();
    mem_ack = 1'b1; step();
    step();
    idle(); step();
    // Timeout with no ack: four stalls, forced release, sticky error.
    do_reset();
    mem_req_me = 1'b1;
    repeat (5) step();
    idle(); repeat (2) step();
    // Memory stall over a simultaneous redirect and load-use.
    do_reset();
    mem_req_me = 1'b1; redirect_ex = 1'b1;
    rw_ex = 5'd9; wreg_ex = 1'b1; m2reg_ex = 1'b1; rt_id = 5'd9; use_rt_id = 1'b1;
    repeat (2) step();
    mem_ack = 1'b1; step();
    idle(); step();
    // Random phase: long run without reset (reaches counter saturation), then with resets.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      reset_0     = (i > 1500) ? ($urandom_range(0, 99) != 0) : 1'b1;
      rs_id       = 5'($urandom_range(0, 3));
      rt_id       = 5'($urandom_range(0, 3));
      rw_ex       = 5'($urandom_range(0, 3));
      rw_me       = 5'($urandom_range(0, 3));
      rw_wb       = 5'($urandom_range(0, 3));
      use_rs_id   = 1'($urandom_range(0, 1));
      use_rt_id   = 1'($urandom_range(0, 1));
      wreg_ex     = 1'($urandom_range(0, 1));
      m2reg_ex    = 1'($urandom_range(0, 1));
      wreg_me     = 1'($urandom_range(0, 1));
      m2reg_me    = 1'($urandom_range(0, 1));
      wreg_wb     = 1'($urandom_range(0, 1));
      mem_req_me  = ($urandom_range(0, 9) < 4);
      mem_ack     = ($urandom_range(0, 9) < 4);
      redirect_ex = ($urandom_range(0, 9) < 2);
      step();
    end
    reset_0 = 1'b1; idle();
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and stall controller for the 5-stage pipeline.
- Drives the enable and bubble controls of the PC, IF/ID, ID/EX, EX/ME and ME/WB registers.
- Generates the ID-stage forwarding selects.
- Sequences data-memory wait states with a timeout and error flag, and counts stall cycles for performance monitoring.

Parameters:
MEM_TIMEOUT, 15, max consecutive un-acked memory cycles before forced release (1..255)
CNT_W, 32, width of stall_cnt

Ports:
clock  in  1  system clock, rising edge
reset_0  in  1  asynchronous active-low reset
rs_id  in  5  ID-stage source register rs
rt_id  in  5  ID-stage source register rt
use_rs_id  in  1  ID instruction reads rs
use_rt_id  in  1  ID instruction reads rt
rw_ex  in  5  EX-stage destination register
wreg_ex  in  1  EX instruction writes register
m2reg_ex  in  1  EX instruction is a load
rw_me  in  5  ME-stage destination register
wreg_me  in  1  ME instruction writes register
m2reg_me  in  1  ME instruction is a load
mem_req_me  in  1  ME instruction accesses data memory
mem_ack  in  1  data memory completes access this cycle
rw_wb  in  5  WB-stage destination register
wreg_wb  in  1  WB instruction writes register
redirect_ex  in  1  taken branch/jump resolved in EX
en_pc, en_ifid, en_idex, en_exme, en_mewb  out  1 each  register load enables
bubble_ifid, bubble_idex, bubble_mewb  out  1 each  load NOP (all control zero) instead of data; only meaningful with the matching enable=1
fwd_a, fwd_b  out  2 each  operand select for rs/rt: 00 regfile, 01 ME ALU result, 10 ME load data, 11 WB result
mem_err  out  1  sticky memory timeout flag
stall_cnt  out  CNT_W  cycles in which en_pc=0

Behaviour:
- FSM states RUN and MWAIT, plus an 8-bit wait_cnt. Reset (reset_0=0, async): state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0.
- While reset_0=0, all enables=0, all bubbles=0, fwd_a=fwd_b=00.
- mstall = mem_req_me & ~mem_ack & ~(state==MWAIT & wait_cnt==MEM_TIMEOUT).
- luse = wreg_ex & m2reg_ex & rw_ex!=0 & ((use_rs_id & rs_id==rw_ex) | (use_rt_id & rt_id==rw_ex)).
- Priority is mstall > redirect_ex > luse > normal. Outputs are combinational from state, wait_cnt and inputs.
- mstall: freeze the whole pipe. en_pc, en_ifid, en_idex, en_exme = 0; en_mewb=1 with bubble_mewb=1, so WB never repeats a write. redirect_ex and luse are held, not acted on.
- redirect_ex: all enables=1, bubble_ifid=1, bubble_idex=1 (flush the two wrong-path instructions).
- luse: en_pc=en_ifid=0; en_idex=1 with bubble_idex=1; en_exme=en_mewb=1. Exactly one bubble per load-use pair.
- Normal: all enables 1, bubbles 0.
- Forwarding, per operand, independently for rs/rt:
  - Register 0 is never forwarded and gives 00.
  - Priority: ME over WB.
  - Match ME (wreg_me, rw_me==reg) gives 10 if m2reg_me, else 01.
  - Else match WB (wreg_wb) gives 11.
  - Else 00.
- FSM:
  - RUN -> MWAIT when mem_req_me & ~mem_ack; wait_cnt becomes 1.
  - MWAIT with mem_ack=1 -> RUN; wait_cnt becomes 0.
  - MWAIT with ~mem_ack and wait_cnt<MEM_TIMEOUT: wait_cnt increments.
  - MWAIT with ~mem_ack and wait_cnt==MEM_TIMEOUT: forced release. mstall=0 that cycle so the pipe advances, mem_err is set (sticky until reset), -> RUN, wait_cnt becomes 0.
  - An ack in the same cycle as the request gives zero stall cycles and stays in RUN.
- stall_cnt increments on every clock edge where en_pc=0 and reset_0=1. It saturates at all-ones and does not wrap.
- Reset asserted mid-MWAIT: immediate return to RUN, flag and counters clear.

Test Plan:
- Reset: hold reset_0=0 with mem_req_me=1, mem_ack=0, redirect_ex=1 -> all enables 0, bubbles 0, mem_err=0, stall_cnt=0; release -> mstall behaviour starts in the next cycle.
- Load-use: EX lw rw_ex=5 (wreg_ex=m2reg_ex=1), ID rs_id=5 use_rs_id=1 -> one cycle en_pc=en_ifid=0, bubble_idex=1; next cycle (load now in ME) fwd_a=10, all enables 1; stall_cnt=1.
- Forward priority: rw_me=7 ALU, rw_wb=7, rs_id=rt_id=7 -> fwd_a=fwd_b=01. rw_me=0 with wreg_me=1 and rs_id=0 -> fwd_a=00.
- Memory wait 3 cycles: mem_req_me=1, ack low 3 cycles then high -> en_pc=0 and bubble_mewb=1 for exactly 3 cycles, FSM back to RUN, stall_cnt=3, mem_err=0.
- Timeout MEM_TIMEOUT=4, ack never: stall for 4 cycles; in the 5th request cycle, release with enables=1 and mem_err=1 thereafter; stall_cnt=4.
- Simultaneous: redirect_ex=1 and luse=1 with mem stall for 2 cycles -> frozen for 2 cycles, then flush (bubble_ifid=bubble_idex=1, en_pc=1), no load-use stall.
